// File: rtl/crpa_cov_macc.sv
// Covariance multiply-accumulate for an NCH-channel CRPA front end: the upper-triangle
// sums of s_i*s_j over 2^div samples, scaled by >>div. Define CRPA_COV_ROUND_EN for rounded scaling.
//
// state | meaning
// IDLE  | waiting for cm_macc_en; results and ready held
// ACC   | capturing one sample per clk into the pipeline
// DONE  | single-shot block captured; waits for cm_macc_en low and pipeline drain
module crpa_cov_macc #(
  parameter int NCH     = 8,
  parameter int WIDTH   = 14,
  parameter int MAX_DIV = 16,
  parameter int ADDR_W  = 6
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NCH*WIDTH-1:0]   adc_concat,
  input  logic                   cm_macc_en,
  input  logic                   cm_macc_mod,
  input  logic [4:0]             cm_macc_div,
  output logic                   cm_macc_ready,
  input  logic [ADDR_W-1:0]      cm_rd_addr,
  output logic [2*WIDTH-1:0]     cm_rd_data
);
  localparam int NTRI = NCH*(NCH+1)/2;
  localparam int PW   = 2*WIDTH;
  localparam int AW   = 2*WIDTH+MAX_DIV;
  localparam int CW   = MAX_DIV+1;
  localparam logic [ADDR_W-1:0] NTRI_A = ADDR_W'(NTRI);

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  state_t          state_q;
  logic [4:0]      div_q;
  logic            mod_q;
  logic [CW-1:0]   cnt_q;
  logic [CW-1:0]   n_m1;
  logic            ready_q;
  logic            start, cap, abort, last, busy;
  logic            v1_q, f1_q, l1_q, v2_q, f2_q, l2_q, fin_q;

  logic signed [WIDTH-1:0] smp_q  [NCH];
  logic signed [PW-1:0]    prod_q [NTRI];
  logic signed [AW-1:0]    acc_q  [NTRI];
  logic signed [PW-1:0]    res_q  [NTRI];
  logic signed [PW-1:0]    res_d  [NTRI];

  assign n_m1  = (CW'(1) << div_q) - CW'(1);
  assign start = (state_q == IDLE) && cm_macc_en;
  assign cap   = (state_q == ACC) && cm_macc_en;
  assign abort = (state_q == ACC) && !cm_macc_en;
  assign last  = (cnt_q == n_m1);
  assign busy  = v1_q | v2_q | fin_q;
  assign cm_macc_ready = ready_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      div_q   <= '0;
      mod_q   <= 1'b0;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      if (fin_q) ready_q <= 1'b1;
      unique case (state_q)
        IDLE: if (cm_macc_en) begin
          state_q <= ACC;
          cnt_q   <= '0;
          div_q   <= (cm_macc_div > 5'(MAX_DIV)) ? 5'(MAX_DIV) : cm_macc_div;
          mod_q   <= cm_macc_mod;
          if (!cm_macc_mod) ready_q <= 1'b0;
        end
        ACC: if (!cm_macc_en) begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end else if (last) begin
          cnt_q <= '0;
          if (!mod_q) state_q <= DONE;
        end else begin
          cnt_q <= cnt_q + CW'(1);
        end
        // Leaving DONE only once the last block has latched keeps a quick re-request from disturbing it.
        DONE: if (!cm_macc_en && !busy) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      {v1_q, f1_q, l1_q, v2_q, f2_q, l2_q, fin_q} <= '0;
      for (int k = 0; k < NCH; k++) smp_q[k] <= '0;
      for (int k = 0; k < NTRI; k++) begin
        prod_q[k] <= '0;
        acc_q[k]  <= '0;
        res_q[k]  <= '0;
      end
    end else begin
      v1_q  <= cap;
      f1_q  <= (cnt_q == '0);
      l1_q  <= last;
      v2_q  <= v1_q && !abort;
      f2_q  <= f1_q;
      l2_q  <= l1_q;
      fin_q <= v2_q && l2_q && !abort;
      if (cap)
        for (int k = 0; k < NCH; k++) smp_q[k] <= adc_concat[k*WIDTH +: WIDTH];
      if (v1_q)
        for (int i = 0; i < NCH; i++)
          for (int j = i; j < NCH; j++)
            prod_q[i*NCH - (i*(i-1))/2 + (j-i)] <= PW'(smp_q[i]) * PW'(smp_q[j]);
      // The first product of a block loads rather than adds, so continuous blocks need no gap.
      for (int k = 0; k < NTRI; k++) begin
        if (start || abort) acc_q[k] <= '0;
        else if (v2_q)      acc_q[k] <= f2_q ? AW'(prod_q[k]) : acc_q[k] + AW'(prod_q[k]);
      end
      if (fin_q)
        for (int k = 0; k < NTRI; k++) res_q[k] <= res_d[k];
    end
  end

`ifdef CRPA_COV_ROUND_EN
  logic signed [AW-1:0] rnd;
  assign rnd = (div_q == 5'd0) ? '0 : (AW'(1) << (div_q - 5'd1));
  always_comb begin
    for (int k = 0; k < NTRI; k++) res_d[k] = PW'((acc_q[k] + rnd) >>> div_q);
  end
`else
  always_comb begin
    for (int k = 0; k < NTRI; k++) res_d[k] = PW'(acc_q[k] >>> div_q);
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                    cm_rd_data <= '0;
    else if (cm_rd_addr < NTRI_A) cm_rd_data <= fin_q ? res_d[cm_rd_addr] : res_q[cm_rd_addr];
    else                          cm_rd_data <= '0;
  end

endmodule

// File: doc/crpa_cov_macc.md
CRPA_COV_MACC -- requirements
Module: crpa_cov_macc

Interface
REQ-001 Parameters (name, default, meaning), SHALL be:
- NCH, 8: number of antenna channels.
- WIDTH, 14: signed ADC sample width.
- MAX_DIV, 16: maximum log2 of the accumulation length.
- ADDR_W, 6: read-address width; SHALL satisfy 2^ADDR_W >= NCH*(NCH+1)/2.
REQ-002 Ports (name, direction, width, meaning), SHALL be:
- clk, in, 1: the single clock.
- reset, in, 1: asynchronous, active-high reset.
- adc_concat, in, NCH*WIDTH: signed samples; channel k occupies bits [(k+1)*WIDTH-1 : k*WIDTH]; one new sample per clk.
- cm_macc_en, in, 1: level request to accumulate.
- cm_macc_mod, in, 1: 0 = single-shot, 1 = continuous.
- cm_macc_div, in, 5: log2 N, where N is the number of samples per block.
- cm_macc_ready, out, 1: result registers hold a complete block.
- cm_rd_addr, in, ADDR_W: index of a covariance element.
- cm_rd_data, out, 2*WIDTH: signed covariance element.

Function
REQ-003 The block SHALL compute R(i,j) = (sum over N samples of s_i*s_j) >> div for 0<=i<=j<NCH (upper triangle only), using an arithmetic right shift.
REQ-004 The element address SHALL be i*NCH - i*(i-1)/2 + (j-i): (0,0)=0, (0,7)=7, (1,1)=8, (7,7)=35.
REQ-005 The FSM SHALL have three states: IDLE, ACC and DONE; reset SHALL enter IDLE.
REQ-006 In IDLE with cm_macc_en=1, the FSM SHALL go to ACC, clear the accumulators and sample counter, and latch cm_macc_div and cm_macc_mod; if cm_macc_mod=0, cm_macc_ready SHALL be cleared on the same edge.
REQ-007 A latched div greater than MAX_DIV SHALL be clamped to MAX_DIV.
REQ-008 The N samples accumulated SHALL be those present on the N clk cycles immediately after the cycle in which cm_macc_en was sampled high in IDLE.
REQ-009 The datapath SHALL have a fixed latency: an input register, a product register, and an accumulator of width 2*WIDTH+MAX_DIV; the results SHALL be scaled and latched into the result registers, and cm_macc_ready SHALL be 1, exactly 3 clk after the final sample cycle.
REQ-010 Results SHALL never saturate; a scaled mean always fits in 2*WIDTH signed bits.
REQ-011 After completing a block with mode 0, the FSM SHALL stay in DONE while cm_macc_en=1 and SHALL go to IDLE when cm_macc_en=0; cm_macc_ready SHALL stay 1 in both cases.
REQ-012 In mode 1, after each block the FSM SHALL restart ACC with no gap cycle; the result registers SHALL update every N cycles and cm_macc_ready SHALL stay 1.
REQ-013 cm_macc_en=0 during ACC SHALL abort to IDLE: the partial sums SHALL be discarded, and the result registers and cm_macc_ready SHALL be unchanged.
REQ-014 cm_rd_data SHALL be registered with a latency of 1 clk from cm_rd_addr; an address >= NCH*(NCH+1)/2 SHALL return 0.
REQ-015 A read in the same cycle as a result latch SHALL return the newly latched value on the following clk.
REQ-016 cm_macc_div, cm_macc_mod and cm_macc_en changes outside IDLE SHALL have no effect, except the abort defined in REQ-013.

Reset
REQ-017 Asserting reset at any time, including mid-ACC, SHALL asynchronously set: FSM to IDLE, all accumulators, result registers and counters to 0, cm_macc_ready=0 and cm_rd_data=0.
REQ-018 Operation SHALL resume on the first clk edge after reset deasserts.

Configuration
REQ-019 With CRPA_COV_ROUND_EN defined, scaling SHALL be (sum + 2^(div-1)) >> div for div>0, and a plain shift for div=0.
REQ-020 Without CRPA_COV_ROUND_EN, scaling SHALL be a truncating arithmetic shift; no rounding logic SHALL be compiled in.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Ch0=100, other channels 0, div=4, mode 0 -> addr0 reads 10000, all other addresses read 0, and ready rises 3 clk after the 16th sample.
- Ch0=+1000, ch1=-1000, div=2 -> addr1 reads -1000000; addr0 and addr8 read 1000000.
- All channels -8192, div=0 -> every address 0..35 reads 67108864; addr 40 reads 0.
- Ch0 alternating 1,2 with div=1 -> addr0 reads 2 without CRPA_COV_ROUND_EN and 3 with it.
- Mode 0 block done (addr0=10000), then a new request with ch0=0 and cm_macc_en dropped after 5 samples -> IDLE, ready=0, addr0 still reads 10000.
- Mode 1, div=3, reset asserted mid-block -> ready=0 and all reads return 0 immediately; after release, a new request completes normally.
